// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratio and the
// frame-format defaults used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (start / DBIT data LSB first / SB_TICK stop).
// Define UART_RX_FRAME_ERR_EN to add the frame_err output and its logic.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam int NW = cnt_width(DBIT);
  // The tick counter must also reach SB_TICK-1 for 1.5/2 stop-bit intervals.
  localparam int SW = (cnt_width(SB_TICK) > cnt_width(OVERSAMPLE)) ?
                      cnt_width(SB_TICK) : cnt_width(OVERSAMPLE);

  localparam logic [SW-1:0] MID_TICK  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_TICK = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

  logic            w_rx_s;
  logic            w_stop_done;
  logic [DBIT:0]   w_shift;

  uart_state_t     r_state;
  uart_state_t     w_state_nxt;
  logic [SW-1:0]   r_s_cnt;
  logic [SW-1:0]   w_s_cnt_nxt;
  logic [NW-1:0]   r_n_cnt;
  logic [NW-1:0]   w_n_cnt_nxt;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] w_b_nxt;
  logic [DBIT-1:0] r_dout;
  logic [DBIT-1:0] w_dout_nxt;
  logic            r_done;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  assign w_shift     = {w_rx_s, r_b};
  assign w_stop_done = (r_state == STOP) && s_tick && (r_s_cnt == STOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_b     <= w_b_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_stop_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_cnt_nxt = '0;
        end
      end
      START: begin
        // A line that is high again at mid-start was only a glitch.
        if (s_tick) begin
          if (r_s_cnt == MID_TICK) begin
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_s_cnt_nxt = '0;
              w_n_cnt_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s_cnt == LAST_TICK) begin
            w_b_nxt     = w_shift[DBIT:1];
            w_s_cnt_nxt = '0;
            if (r_n_cnt == LAST_BIT) begin
              w_state_nxt = STOP;
            end else begin
              w_n_cnt_nxt = r_n_cnt + 1'b1;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s_cnt == STOP_LAST) begin
            w_dout_nxt  = r_b;
            w_state_nxt = IDLE;
          end else begin
            w_s_cnt_nxt = r_s_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;

`ifdef UART_RX_FRAME_ERR_EN
  logic r_ferr;

  // Flag a low stop sample on the same edge that completes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= w_stop_done && !w_rx_s;
    end
  end

  assign frame_err = r_ferr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (8N1 default plus an SB_TICK=32 instance).
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic [7:0] dout32;
  logic       done;
  logic       done32;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr;
  logic       ferr32;
`endif

  int tick_per         = 8;
  int tick_total       = 0;
  int done_cnt         = 0;
  int done32_cnt       = 0;
  int last_done_tick   = 0;
  int last_done32_tick = 0;
  int ferr_cnt         = 0;
  int ferr_done_cnt    = 0;
  int frame_t0         = 0;
  int tests            = 0;
  int fails            = 0;

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (done)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err    (ferr)
`endif
  );

  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout32),
    .rx_done_tick (done32)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err    (ferr32)
`endif
  );

  initial begin
    int cnt;
    cnt    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt >= tick_per - 1) begin
        s_tick = 1'b1;
        cnt    = 0;
      end else begin
        s_tick = 1'b0;
        cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (s_tick) tick_total <= tick_total + 1;
    if (done) begin
      done_cnt       <= done_cnt + 1;
      last_done_tick <= tick_total;
    end
    if (done32) begin
      done32_cnt       <= done32_cnt + 1;
      last_done32_tick <= tick_total;
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ferr && done) ferr_done_cnt <= ferr_done_cnt + 1;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  // Starts at the negedge after the current tick; frame_t0 is that tick's index.
  task automatic send_frame(input logic [7:0] d, input int nstop, input bit stop_low);
    @(negedge clk);
    rx       = 1'b0;
    frame_t0 = tick_total;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = d[i];
      wait_ticks(16);
    end
    @(negedge clk);
    if (stop_low) begin
      rx = 1'b0;
      wait_ticks(8);
      @(negedge clk);
      rx = 1'b1;
      wait_ticks(24);
    end else begin
      rx = 1'b1;
      wait_ticks(16 * nstop);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++;
    if (dut.r_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
    tests++;
    if (dut.w_rx_s !== 1'b1) begin fails++; $display("FAIL reset_sync: got %b want 1", dut.w_rx_s); end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int d0;
    tick_per = 100;
    wait_ticks(2);
    d0 = done_cnt;
    send_frame(8'hA5, 1, 1'b0);
    wait_ticks(4);
    #1;
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    tests++;
    if (dout !== 8'hA5) begin fails++; $display("FAIL basic_dout: got %h want a5", dout); end
    tests++;
    if (last_done_tick - frame_t0 !== 152) begin
      fails++; $display("FAIL basic_latency: got %0d ticks want 152", last_done_tick - frame_t0);
    end
    tests++;
    if (dut.r_state !== IDLE) begin fails++; $display("FAIL basic_idle: got %0d want IDLE", dut.r_state); end
  endtask

  task automatic test_back_to_back;
    int d0;
    tick_per = 8;
    wait_ticks(2);
    d0 = done_cnt;
    send_frame(8'h00, 1, 1'b0);
    #1;
    tests++;
    if (dout !== 8'h00) begin fails++; $display("FAIL b2b_first_dout: got %h want 00", dout); end
    send_frame(8'hFF, 1, 1'b0);
    wait_ticks(4);
    #1;
    tests++;
    if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    tests++;
    if (dout !== 8'hFF) begin fails++; $display("FAIL b2b_second_dout: got %h want ff", dout); end
  endtask

  task automatic test_glitch;
    int d0;
    logic [7:0] prev;
    d0   = done_cnt;
    prev = dout;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(20);
    #1;
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL glitch_no_done: got %0d want %0d", done_cnt, d0); end
    tests++;
    if (dout !== prev) begin fails++; $display("FAIL glitch_dout_held: got %h want %h", dout, prev); end
    tests++;
    if (dut.r_state !== IDLE) begin fails++; $display("FAIL glitch_idle: got %0d want IDLE", dut.r_state); end
  endtask

  task automatic test_stop_low;
    int d0;
    int f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1, 1'b1);
    wait_ticks(4);
    #1;
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL stoplow_done_count: got %0d want 1", done_cnt - d0); end
    tests++;
    if (dout !== 8'h3C) begin fails++; $display("FAIL stoplow_dout: got %h want 3c", dout); end
`ifdef UART_RX_FRAME_ERR_EN
    tests++;
    if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    tests++;
    if (ferr_done_cnt - f0 !== 1) begin
      fails++; $display("FAIL ferr_with_done: got %0d want 1", ferr_done_cnt - f0);
    end
    f0 = ferr_cnt;
`endif
    send_frame(8'h66, 1, 1'b0);
    wait_ticks(4);
    #1;
    tests++;
    if (dout !== 8'h66) begin fails++; $display("FAIL stopok_dout: got %h want 66", dout); end
`ifdef UART_RX_FRAME_ERR_EN
    tests++;
    if (ferr_cnt !== f0) begin fails++; $display("FAIL ferr_valid_stop: got %0d want %0d", ferr_cnt, f0); end
`endif
  endtask

  task automatic test_reset_midframe;
    int d0;
    logic [7:0] d;
    d  = 8'h5A;
    d0 = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = d[i];
      wait_ticks(16);
    end
    @(negedge clk);
    rx = d[4];
    wait_ticks(8);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (dout !== 8'h00) begin fails++; $display("FAIL midrst_dout_cleared: got %h want 00", dout); end
    rx    = 1'b1;
    rst_n = 1'b1;
    wait_ticks(40);
    #1;
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL midrst_no_done: got %0d want %0d", done_cnt, d0); end
    send_frame(8'hC3, 1, 1'b0);
    wait_ticks(4);
    #1;
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL midrst_done_count: got %0d want 1", done_cnt - d0); end
    tests++;
    if (dout !== 8'hC3) begin fails++; $display("FAIL midrst_dout: got %h want c3", dout); end
  endtask

  task automatic test_sb32;
    int d0;
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
    d0 = done32_cnt;
    send_frame(8'h81, 2, 1'b0);
    wait_ticks(4);
    #1;
    tests++;
    if (done32_cnt - d0 !== 1) begin fails++; $display("FAIL sb32_done_count: got %0d want 1", done32_cnt - d0); end
    tests++;
    if (dout32 !== 8'h81) begin fails++; $display("FAIL sb32_dout: got %h want 81", dout32); end
    tests++;
    if (last_done32_tick - frame_t0 !== 168) begin
      fails++; $display("FAIL sb32_latency: got %0d ticks want 168", last_done32_tick - frame_t0);
    end
    tests++;
    if (dout !== 8'h81) begin fails++; $display("FAIL sb16_two_stop_dout: got %h want 81", dout); end
  endtask

  task automatic test_tick_high;
    int d0;
    tick_per = 1;
    wait_ticks(4);
    d0 = done_cnt;
    send_frame(8'h96, 1, 1'b0);
    wait_ticks(8);
    #1;
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL tickhigh_done_count: got %0d want 1", done_cnt - d0); end
    tests++;
    if (dout !== 8'h96) begin fails++; $display("FAIL tickhigh_dout: got %h want 96", dout); end
    tests++;
    if (last_done_tick - frame_t0 !== 155) begin
      fails++; $display("FAIL tickhigh_latency: got %0d ticks want 155", last_done_tick - frame_t0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_stop_low();
    test_reset_midframe();
    test_sb32();
    test_tick_high();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
